// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_INC  = 2;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    ISSUE,
    INJECT,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding fetch stage feeding the decoder
// One request in flight; the decoder's branch/inject/end outputs pick the next PC.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               imem_valid_i,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic [INSTR_W-1:0] self_instruct_i,
  input  logic               self_instruct_en_i,
  input  logic               end_program_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               halted_o
);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] r_inj;

  logic               w_presenting;
  logic [ADDR_W-1:0]  w_pc_seq;
  logic [ADDR_W-1:0]  w_pc_branch;

  assign w_presenting = (r_state == ISSUE) || (r_state == INJECT);
  assign w_pc_seq     = r_pc + ADDR_W'(PC_INC);
  // Instructions are halfword aligned, so the target's bit 0 is dropped.
  assign w_pc_branch  = branch_target_i & ~ADDR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_inj   <= '0;
    end else begin
      case (r_state)
        FETCH: r_state <= WAIT;
        WAIT: begin
          if (imem_valid_i) begin
            r_ir    <= imem_rdata_i;
            r_state <= ISSUE;
          end
        end
        ISSUE, INJECT: begin
          // A stalled instruction is not consumed, so decoder outputs are ignored.
          if (!stall_i) begin
            if (end_program_i) begin
              r_state <= HALT;
            end else if (branch_i) begin
              r_pc    <= w_pc_branch;
              r_state <= FETCH;
            end else if (self_instruct_en_i && (r_state == ISSUE)) begin
              r_inj   <= self_instruct_i;
              r_state <= INJECT;
            end else begin
              r_pc    <= w_pc_seq;
              r_state <= FETCH;
            end
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign imem_req_o    = (r_state == FETCH) && !rst_i;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_presenting;
  assign instr_o       = (r_state == INJECT) ? r_inj : r_ir;
  assign pc_o          = r_pc;
  assign halted_o      = (r_state == HALT);

endmodule
